// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed 4-digit active-low 7-segment bus.
// It debounces each digit, decodes it to BCD and emits whole frames with a one-cycle strobe.
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] bcd_out,
    output logic [3:0]  blank_out,
    output logic [3:0]  err_out,
    output logic        frame_valid,
    output logic [3:0]  digits_seen
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic        prev_valid_q, prev_valid_d;
    logic [1:0]  prev_idx_q, prev_idx_d;
    logic [0:6]  prev_seg_q, prev_seg_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] shadow_code_q, shadow_code_d;
    logic [3:0]  shadow_blank_q, shadow_blank_d;
    logic [3:0]  shadow_err_q, shadow_err_d;
    logic [3:0]  digits_seen_q, digits_seen_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  err_q, err_d;
    logic        frame_valid_q, frame_valid_d;

    logic        legal;
    logic [1:0]  idx;
    logic        same;
    logic        loaded;
    logic        accept;
    logic [3:0]  code;
    logic        is_blank;
    logic        is_err;
    logic [3:0]  seen_next;

    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (an_in)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    // Pattern literals are written a..g left to right, matching seg_in[0:6].
    always_comb begin
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg_in)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111111: begin code = 4'hF; is_blank = 1'b1; end
            default:    begin code = 4'hE; is_err   = 1'b1; end
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        prev_valid_d   = prev_valid_q;
        prev_idx_d     = prev_idx_q;
        prev_seg_d     = prev_seg_q;
        cnt_d          = cnt_q;
        shadow_code_d  = shadow_code_q;
        shadow_blank_d = shadow_blank_q;
        shadow_err_d   = shadow_err_q;
        digits_seen_d  = digits_seen_q;
        bcd_d          = bcd_q;
        blank_d        = blank_q;
        err_d          = err_q;
        frame_valid_d  = 1'b0;
        loaded         = 1'b0;
        accept         = 1'b0;
        same           = prev_valid_q && (idx == prev_idx_q) && (seg_in == prev_seg_q);
        seen_next      = digits_seen_q | (4'b0001 << idx);

        if (!legal) begin
            cnt_d        = 8'd0;
            prev_valid_d = 1'b0;
        end else begin
            prev_valid_d = 1'b1;
            prev_idx_d   = idx;
            prev_seg_d   = seg_in;
            if (same) begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_d  = 8'd1;
                loaded = 1'b1;
            end
            // A saturated counter that stays at its value has not "become" the threshold again.
            accept = (cnt_d == STABLE_CNT) && (loaded || (cnt_q != cnt_d));
        end

        if (accept) begin
            shadow_code_d[idx*4 +: 4] = code;
            shadow_blank_d[idx]       = is_blank;
            shadow_err_d[idx]         = is_err;
            if (seen_next == 4'b1111) begin
                bcd_d         = shadow_code_d;
                blank_d       = shadow_blank_d;
                err_d         = shadow_err_d;
                frame_valid_d = 1'b1;
                digits_seen_d = 4'b0000;
            end else begin
                digits_seen_d = seen_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            prev_valid_q   <= 1'b0;
            prev_idx_q     <= 2'd0;
            prev_seg_q     <= '0;
            cnt_q          <= 8'd0;
            // NOTE: shadow slots are reset too, so no stale digit from before reset can leak into a frame.
            shadow_code_q  <= '0;
            shadow_blank_q <= '0;
            shadow_err_q   <= '0;
            digits_seen_q  <= '0;
            bcd_q          <= '0;
            blank_q        <= '0;
            err_q          <= '0;
            frame_valid_q  <= 1'b0;
        end else begin
            prev_valid_q   <= prev_valid_d;
            prev_idx_q     <= prev_idx_d;
            prev_seg_q     <= prev_seg_d;
            cnt_q          <= cnt_d;
            shadow_code_q  <= shadow_code_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_err_q   <= shadow_err_d;
            digits_seen_q  <= digits_seen_d;
            bcd_q          <= bcd_d;
            blank_q        <= blank_d;
            err_q          <= err_d;
            frame_valid_q  <= frame_valid_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign blank_out   = blank_q;
    assign err_out     = err_q;
    assign frame_valid = frame_valid_q;
    assign digits_seen = digits_seen_q;

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
Receive-side counterpart of the team's BCD-to-7-segment driver. Monitors a multiplexed 4-digit, active-low 7-segment bus (segment lines plus digit enables). Each digit pattern is qualified by a stability filter and decoded back to BCD. A complete 4-digit frame is presented with a one-cycle valid strobe. Used in self-check loops and board bring-up to read back what the display logic is driving.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a digit pattern is accepted (legal range 1..255).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
seg_in  input  [0:6]  segment lines, active-low; bit 0 = a … bit 6 = g
an_in  input  4  digit enables, active-low; an_in[i]=0 selects digit i
bcd_out  output  16  frame value; bcd_out[4i+3:4i] = digit i
blank_out  output  4  per-digit flag; 1 = digit was blank
err_out  output  4  per-digit flag; 1 = digit pattern was not legal
frame_valid  output  1  one-cycle strobe; new frame is on bcd_out/blank_out/err_out
digits_seen  output  4  digits captured so far in the current frame

Behaviour:
- Reset: all outputs 0. Shadow registers, stability counter and previous-sample registers cleared. Applies on the next clk edge with rst=1, including mid-dwell and mid-frame; no partial frame survives.
- Legal sample: an_in has exactly one zero bit (1110, 1101, 1011, 0111). Any other an_in value (none low, or several low):
  - clears the stability counter;
  - sample is discarded;
  - digits_seen is unchanged.
- Stability filter: on a legal sample, compare (digit index, seg_in) with the previous cycle's legal sample.
  - Equal: increment the counter, saturating at 255.
  - Different, or previous cycle illegal: load the counter with 1.
- Accept: a digit is accepted on the edge where the counter value becomes exactly STABLE_CYCLES. With STABLE_CYCLES=1, every new dwell is accepted on its first sample. A long dwell is accepted once only.
- Decode table (seg_in a..g -> code):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9
  - 1111111 -> code 4'hF with blank flag set
  - any other pattern -> code 4'hE with err flag set
- On accept of digit i:
  - write code, blank flag and err flag into shadow slot i;
  - set digits_seen[i].
  - If digit i is accepted again before the frame completes, the newer value overwrites the slot.
- Frame completion: on the edge where digits_seen would become 4'b1111:
  - copy all shadow slots (including the slot being written that edge) to bcd_out, blank_out and err_out;
  - pulse frame_valid for exactly that one cycle;
  - clear digits_seen to 0 on that same edge.
- Output hold: bcd_out, blank_out and err_out hold their value between frames.
- Latency: a dwell starting at edge k is accepted at edge k+STABLE_CYCLES-1. When it completes a frame, frame_valid and the new outputs are visible after that same edge.
- Simultaneous events: rst has priority over accept and frame completion. An illegal an_in on an edge blocks accept on that edge.
- Arithmetic: counter is 8 bits, no wrap. Digit index is 2 bits, from a one-hot-low encode of an_in.

Test Plan:
- Reset, then an_in cycles 1110,1101,1011,0111, each held 4 cycles, seg_in = patterns for 1,2,3,4 -> one frame_valid pulse; bcd_out=16'h4321; blank_out=0; err_out=0; digits_seen returns to 0.
- Same scan, but digit 2 is held only 3 cycles with STABLE_CYCLES=4 -> no frame_valid; digits_seen=4'b1011. A later 4-cycle dwell on digit 2 with pattern 7 -> frame with bcd_out=16'h4721.
- Digit 3 driven 1111111, digit 0 driven 1111110 -> bcd_out[15:12]=F with blank_out[3]=1; bcd_out[3:0]=E with err_out[0]=1.
- an_in=1100 inserted mid-dwell of digit 1 -> counter restarts; acceptance is delayed by the full STABLE_CYCLES after the glitch.
- Digit 0 held for 20 cycles -> accepted once; digits_seen[0] is set once; no extra frames.
- rst asserted for 1 cycle after 3 digits captured -> all outputs and digits_seen are 0; the next complete scan yields exactly one frame.
